// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//
// Rebuilds one parallel word from an idle-high serial line. The frame is a start
// bit (0), DATA_WIDTH data bits LSB first, an optional parity bit and a stop bit (1).
// Each bit lasts OVERSAMPLE clock cycles. The bit value is a 3-sample majority vote
// taken around mid-bit.
//
// Ports:
//   clk        receiver clock, OVERSAMPLE x bit rate
//   rst        asynchronous reset, active low
//   RX_in      serial line, asynchronous to clk, idle high
//   par_en     1 = frame carries a parity bit (latched at frame start)
//   par_typ    0 = even, 1 = odd parity (latched at frame start)
//   p_data     last correctly received word
//   data_valid 1-cycle pulse, p_data updated in the same cycle
//   par_err    1-cycle pulse, parity mismatch on the finished frame
//   stp_err    1-cycle pulse, stop bit sampled 0
//   busy       high while a frame is in progress
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // The counter value is compared in the cycle before the edge that advances it.
  // A sample "at" count k is therefore registered on the edge where the counter
  // moves to k. Likewise, the decision is registered on the edge that reaches
  // OVERSAMPLE/2+1.
  localparam logic [CNT_W-1:0] SAMPLE_0 = CNT_W'(OVERSAMPLE/2 - 2);
  localparam logic [CNT_W-1:0] SAMPLE_1 = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(OVERSAMPLE/2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    sync1;
  logic                    sync2;
  logic                    prev;
  logic [CNT_W-1:0]        edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    samp0;
  logic                    samp1;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_en_l;
  logic                    par_typ_l;
  logic                    par_bad;

  logic voted;
  logic decide;
  logic wrap;
  logic fall;
  logic start_frame;
  logic shift_en;
  logic par_check;
  logic finish;

  assign voted  = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);
  assign decide = (edge_cnt == DECIDE);
  assign wrap   = (edge_cnt == LAST_CNT);
  assign fall   = prev & ~sync2;
  assign busy   = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic and the one-cycle strobes that steer the datapath.
  // The stop bit is resolved at mid-bit, so a back-to-back start edge is not missed.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_check   = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          next_state  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (decide && voted) next_state = IDLE;
        else if (wrap)       next_state = DATA;
      end
      DATA: begin
        shift_en = decide;
        if (wrap && bit_cnt == LAST_BIT) next_state = par_en_l ? PARITY : STOP;
      end
      PARITY: begin
        par_check = decide;
        if (wrap) next_state = STOP;
      end
      STOP: begin
        if (decide) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Line synchronizer plus a delayed copy for falling-edge detection.
  // Reset to idle-high so that leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= RX_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Bit-timing counters and the two early majority samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
    end else begin
      if (state == IDLE || next_state == IDLE) edge_cnt <= '0;
      else if (wrap)                           edge_cnt <= '0;
      else                                     edge_cnt <= edge_cnt + 1'b1;

      if (state != DATA)                 bit_cnt <= '0;
      else if (wrap && bit_cnt == LAST_BIT) bit_cnt <= '0;
      else if (wrap)                     bit_cnt <= bit_cnt + 1'b1;

      if (edge_cnt == SAMPLE_0) samp0 <= sync2;
      if (edge_cnt == SAMPLE_1) samp1 <= sync2;
    end
  end

  // Frame datapath: per-frame parity settings, shift register, parity result
  // and the registered result pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      if (start_frame) begin
        par_en_l  <= par_en;
        par_typ_l <= par_typ;
        par_bad   <= 1'b0;
      end
      if (shift_en)  shift_reg[bit_cnt] <= voted;
      if (par_check) par_bad <= ((^shift_reg) ^ par_typ_l) != voted;

      data_valid <= finish & voted & ~par_bad;
      par_err    <= finish & par_bad;
      stp_err    <= finish & ~voted;
      if (finish && voted && !par_bad) p_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (DATA_WIDTH=8, OVERSAMPLE=8).
// The serial line is driven one clock at a time, so loop index c is the edge
// offset from t0. Result edges are t0+79 without parity and t0+87 with parity.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(8)) dut (
    .clk(clk), .rst(rst), .RX_in(RX_in), .par_en(par_en), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds the line high for n cycles; no result pulse may appear meanwhile.
  task automatic idle_cycles(input int n, input string tag);
    int stray = 0;
    RX_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (data_valid || par_err || stp_err) stray++;
    end
    check_output({tag, "_idle_pulses"}, stray, 0);
  endtask

  // Sends one frame and checks busy timing and the result edge.
  // kind: 0 = data_valid, 1 = par_err, 2 = stp_err.
  // reset_at >= 0 pulls rst low after that edge and abandons the frame.
  task automatic apply_stimulus(input logic [7:0] data, input logic pe, input logic pt,
                                input logic par_flip, input logic stop_val, input logic spike,
                                input int kind, input logic [7:0] exp_pdata,
                                input int reset_at, input string tag);
    logic [10:0] bits;
    int nbits;
    int res_edge;
    int stray = 0;
    logic v;
    logic aborted = 1'b0;
    nbits    = pe ? 11 : 10;
    res_edge = pe ? 87 : 79;
    bits     = '1;
    bits[0]  = 1'b0;
    bits[8:1] = data;
    if (pe) bits[9] = (^data) ^ pt ^ par_flip;
    bits[nbits-1] = stop_val;
    par_en  = pe;
    par_typ = pt;
    for (int c = 0; c < nbits * 8; c++) begin
      v = bits[c / 8];
      if (spike && (c / 8) >= 1 && (c / 8) <= 8 && (c % 8) == 4) v = ~v;
      RX_in = v;
      // Parity settings are latched per frame, so this late change must not matter.
      if (c == 16) begin
        par_en  = ~pe;
        par_typ = ~pt;
      end
      @(posedge clk); #1;
      if (c == reset_at) begin
        check_output({tag, "_busy_before_reset"}, busy, 1);
        rst = 1'b0;
        #1;
        check_output({tag, "_rst_busy"}, busy, 0);
        check_output({tag, "_rst_pdata"}, p_data, 0);
        check_output({tag, "_rst_pulses"}, {data_valid, par_err, stp_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        RX_in = 1'b1;
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (c == 1) check_output({tag, "_busy_t1"}, busy, 0);
      if (c == 2) check_output({tag, "_busy_t2"}, busy, 1);
      if (c == res_edge - 1) check_output({tag, "_busy_before_end"}, busy, 1);
      if (c == res_edge) begin
        check_output({tag, "_data_valid"}, data_valid, kind == 0);
        check_output({tag, "_par_err"}, par_err, kind == 1);
        check_output({tag, "_stp_err"}, stp_err, kind == 2);
        check_output({tag, "_busy_end"}, busy, 0);
        check_output({tag, "_p_data"}, p_data, exp_pdata);
      end else if (data_valid || par_err || stp_err) begin
        stray++;
      end
    end
    RX_in = 1'b1;
    if (!aborted) check_output({tag, "_stray_pulses"}, stray, 0);
  endtask

  initial begin
    int stray;
    $display("[TB] uart_rx directed test start");

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_pdata", p_data, 0);
    check_output("reset_pulses", {data_valid, par_err, stp_err}, 0);
    check_output("reset_busy", busy, 0);
    rst = 1'b1;
    idle_cycles(10, "post_reset");

    // Clean frame, no parity.
    apply_stimulus(8'hA5, 0, 0, 0, 1, 0, 0, 8'hA5, -1, "a5");
    idle_cycles(8, "a5");

    // Even parity, correct then corrupted.
    apply_stimulus(8'h3C, 1, 0, 0, 1, 0, 0, 8'h3C, -1, "3c_par_ok");
    idle_cycles(8, "3c_par_ok");
    apply_stimulus(8'h3C, 1, 0, 1, 1, 0, 1, 8'h3C, -1, "3c_par_bad");
    idle_cycles(8, "3c_par_bad");

    // Odd parity, correct.
    apply_stimulus(8'h07, 1, 1, 0, 1, 0, 0, 8'h07, -1, "07_odd");
    idle_cycles(8, "07_odd");

    // Stop bit low, then a good frame.
    apply_stimulus(8'h55, 0, 0, 0, 0, 0, 2, 8'h07, -1, "55_stop0");
    idle_cycles(16, "55_stop0");
    apply_stimulus(8'h0F, 0, 0, 0, 1, 0, 0, 8'h0F, -1, "0f");
    idle_cycles(8, "0f");

    // Start glitch: three low cycles, then the line returns high.
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      RX_in = (c < 3) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (c == 2) check_output("glitch_busy_t2", busy, 1);
      if (c == 6) check_output("glitch_busy_t6", busy, 1);
      if (c == 7) check_output("glitch_busy_t7", busy, 0);
      if (data_valid || par_err || stp_err) stray++;
    end
    check_output("glitch_pulses", stray, 0);
    check_output("glitch_pdata", p_data, 8'h0F);
    idle_cycles(8, "glitch");

    // Mid-bit single-cycle spikes on every data bit.
    apply_stimulus(8'h96, 0, 0, 0, 1, 1, 0, 8'h96, -1, "96_noise");
    idle_cycles(8, "96_noise");

    // Back-to-back frames with a single stop bit.
    apply_stimulus(8'h01, 0, 0, 0, 1, 0, 0, 8'h01, -1, "b2b_01");
    apply_stimulus(8'hFE, 0, 0, 0, 1, 0, 0, 8'hFE, -1, "b2b_fe");
    idle_cycles(8, "b2b");

    // Reset during data bit 4, then a good frame.
    apply_stimulus(8'h77, 0, 0, 0, 1, 0, 0, 8'h00, 44, "77_reset");
    idle_cycles(10, "77_reset");
    apply_stimulus(8'hC3, 0, 0, 0, 1, 0, 0, 8'hC3, -1, "c3");
    idle_cycles(8, "c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link. It consumes the single-wire stream produced by the transmitter (`TX_out`: idle-high, start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1) and rebuilds the parallel byte. It oversamples each bit `OVERSAMPLE` times and takes a 3-sample majority vote at mid-bit. It reports the byte with a single-cycle `data_valid` pulse and flags framing and parity errors. It sits directly downstream of the TX path and shares its `par_en`/`par_typ` conventions.

## Interface
- `DATA_WIDTH`, 8, data bits per frame.
- `OVERSAMPLE`, 8, `clk` cycles per bit. Must be even and ≥ 6.
- `clk`  in  1  receiver clock, running at `OVERSAMPLE` × bit rate.
- `rst`  in  1  reset, asynchronous, active-low.
- `RX_in`  in  1  serial line, asynchronous to `clk`, idle high.
- `par_en`  in  1  1 = frame carries a parity bit.
- `par_typ`  in  1  0 = even parity, 1 = odd parity (same encoding as TX).
- `p_data`  out  DATA_WIDTH  last correctly received byte.
- `data_valid`  out  1  1-cycle pulse; `p_data` updated this cycle.
- `par_err`  out  1  1-cycle pulse; parity mismatch on the finished frame.
- `stp_err`  out  1  1-cycle pulse; stop bit sampled 0.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- `RX_in` passes through a 2-flop synchronizer (reset value 1). A third register holds the previous synchronized value for falling-edge detection. The FSM uses only synchronized values.
- Counters:
  - `edge_cnt` runs 0..OVERSAMPLE-1 and wraps to 0, advancing one bit.
  - `bit_cnt` runs 0..DATA_WIDTH-1.
- Sampling: samples are taken at `edge_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three, decided at OVERSAMPLE/2+1 (decision edge).
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a synchronized 1→0 edge, go to START with `edge_cnt`=0. Latch `par_en`/`par_typ` for the whole frame; changes mid-frame are ignored.
  - START: at the decision edge, if the voted bit is 1 the frame is a glitch. Return to IDLE with no outputs pulsed. Otherwise go to DATA when `edge_cnt` wraps.
  - DATA: at the decision edge, shift the voted bit into bit position `bit_cnt` (LSB first). After bit DATA_WIDTH-1 wraps, go to PARITY if the latched `par_en`=1, else STOP.
  - PARITY: at the decision edge, compute expected = ^data XOR `par_typ` and compare it with the voted bit. Store the mismatch. Go to STOP on wrap.
  - STOP: at the decision edge, return to IDLE immediately, without waiting for the remainder of the stop bit, so back-to-back frames are caught. On that same edge:
    - voted 0 → `stp_err`=1.
    - parity mismatch → `par_err`=1.
    - neither → `data_valid`=1 and `p_data` ← shift register.
- Both errors can pulse in the same cycle.
- `p_data` changes only when `data_valid` is set. An errored frame leaves `p_data` unchanged.
- Reset asserted mid-frame immediately aborts the frame: state IDLE, counters 0, no pulse.

## Timing
- Reset values: `p_data`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, `busy`=0, state IDLE, synchronizer flops=1.
- t0 is the clk edge at which synchronizer stage 1 first captures `RX_in`=0. START is entered, with `busy` rising, on edge t0+2.
- With P = latched `par_en`, the result pulse is registered on edge t0 + 3 + (9+P)·OVERSAMPLE + OVERSAMPLE/2.
  - OVERSAMPLE=8, P=0: edge t0+79.
  - OVERSAMPLE=8, P=1: edge t0+87.
- `busy` falls on the same edge the result pulse rises.
- All pulses last exactly one cycle. There is no back-pressure; downstream must capture `p_data` on `data_valid`. `p_data` stays stable until the next good frame.
- Tolerance: majority voting at mid-bit tolerates ±(OVERSAMPLE/2-2) cycles of accumulated drift across the frame.

## Test plan
- Clean frame, 0xA5, `par_en`=0, OVERSAMPLE=8 → `data_valid` pulse at t0+79, `p_data`=0xA5, no errors, `busy` high from t0+2 to t0+79.
- 0x3C with `par_en`=1 and `par_typ`=0:
  - correct even parity bit 0 → `data_valid`, `p_data`=0x3C.
  - parity bit forced to 1 → `par_err` pulse at t0+87, `p_data` keeps its previous value.
- Stop bit driven 0 on 0x55 → `stp_err` pulse, no `data_valid`. A following valid frame 0x0F is received correctly.
- Start glitch: `RX_in` low for 3 cycles, then high → return to IDLE, `busy` falls, no pulse of any kind.
- Noise: a single-cycle inverted spike at mid-bit on every data bit of 0x96 → majority vote yields `p_data`=0x96. Back-to-back frames 0x01 then 0xFE with a 1-bit stop → both delivered.
- Reset: `rst` pulsed low during DATA bit 4 → all outputs 0 immediately, state IDLE. The next frame 0xC3 is received correctly.
